// File: rtl/miniRISC_pkg.sv
// Shared definitions for the KGP miniRISC control path: opcode constants,
// sequencer state codes and writeback-source select codes.
package miniRISC_pkg;

  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b011000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Sequencer states; the numeric codes are visible on the state port.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier: splits the 6-bit IR opcode field into
// instruction classes. is_branch covers every branch; is_link marks the
// branch-and-link subset.
module opcode_classifier
  import miniRISC_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_link,
  output logic       is_halt,
  output logic       is_alu
);

  // Class decode; 11xxxx is branch space except the all-ones HALT code.
  always_comb begin
    is_halt   = (opcode == OP_HALT);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode[5:4] == 2'b11) && !is_halt;
    is_link   = is_branch && (opcode[1:0] == 2'b11);
    is_alu    = !(is_halt || is_load || is_store || is_branch);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the miniRISC datapath.
// Owns the memory handshakes, a per-state wait counter for memory timeouts,
// a sticky timeout flag and a retired-instruction counter. All outputs are
// decoded from the registered state plus current inputs, and are held at 0
// while rst is low.
module multicycle_sequencer
  import miniRISC_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             resume,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             reg_read,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             mem_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  // Last wait-counter value allowed before a memory request is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] count_q;

  logic is_load, is_store, is_branch, is_link, is_halt, is_alu;

  logic wait_inc, err_set, retire;

  logic       imem_req_r, ir_load_r, pc_inc_r, pc_branch_r, reg_read_r;
  logic       alu_en_r, dmem_req_r, dmem_we_r, reg_we_r, halted_r;
  logic [1:0] wb_sel_r;

  opcode_classifier u_classifier (
    .opcode    (opcode),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_link   (is_link),
    .is_halt   (is_halt),
    .is_alu    (is_alu)
  );

  // State register, wait counter, sticky error flag and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_q | err_set;
      if (retire) count_q <= count_q + 1'b1;
      if (state_d != state_q) wait_q <= 8'd0;
      else if (wait_inc)      wait_q <= wait_q + 8'd1;
    end
  end

  // Next-state and raw enable decode from registered state and inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wait_inc    = 1'b0;
    err_set     = 1'b0;
    retire      = 1'b0;
    imem_req_r  = 1'b0;
    ir_load_r   = 1'b0;
    pc_inc_r    = 1'b0;
    pc_branch_r = 1'b0;
    reg_read_r  = 1'b0;
    alu_en_r    = 1'b0;
    dmem_req_r  = 1'b0;
    dmem_we_r   = 1'b0;
    reg_we_r    = 1'b0;
    wb_sel_r    = WB_ALU;
    halted_r    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_r = 1'b1;
        if (imem_ready) begin
          ir_load_r = 1'b1;
          pc_inc_r  = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        reg_read_r = 1'b1;
        if (is_halt) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_en_r = 1'b1;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_branch_r = branch_cond;
          if (is_link) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req_r = 1'b1;
        dmem_we_r  = is_store;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_WB: begin
        reg_we_r = 1'b1;
        if (is_load)      wb_sel_r = WB_MEM;
        else if (is_link) wb_sel_r = WB_PC;
        else              wb_sel_r = WB_ALU;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        halted_r = 1'b1;
        if (resume) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Output gating: everything reads as 0 while reset is held.
  always_comb begin
    imem_req    = rst & imem_req_r;
    ir_load     = rst & ir_load_r;
    pc_inc      = rst & pc_inc_r;
    pc_branch   = rst & pc_branch_r;
    reg_read    = rst & reg_read_r;
    alu_en      = rst & alu_en_r;
    dmem_req    = rst & dmem_req_r;
    dmem_we     = rst & dmem_we_r;
    reg_we      = rst & reg_we_r;
    wb_sel      = rst ? wb_sel_r : WB_ALU;
    halted      = rst & halted_r;
    mem_err     = rst & mem_err_q;
    state       = rst ? state_q : 3'd0;
    instr_count = rst ? count_q : '0;
  end

  // is_alu is the fall-through case of the EXEC decode above.
  logic unused_ok;
  assign unused_ok = is_alu;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer, built with a short
// memory timeout and a 2-bit retire counter so timeout boundaries and counter
// wrap are reachable in a few cycles.
module tb_multicycle_sequencer;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 2;

  // Packed output vector bit positions.
  localparam logic [12:0] O_IMEM = 13'h1000;
  localparam logic [12:0] O_IRL  = 13'h0800;
  localparam logic [12:0] O_PCI  = 13'h0400;
  localparam logic [12:0] O_PCB  = 13'h0200;
  localparam logic [12:0] O_RR   = 13'h0100;
  localparam logic [12:0] O_ALU  = 13'h0080;
  localparam logic [12:0] O_DREQ = 13'h0040;
  localparam logic [12:0] O_DWE  = 13'h0020;
  localparam logic [12:0] O_RWE  = 13'h0010;
  localparam logic [12:0] O_WB10 = 13'h0008;
  localparam logic [12:0] O_WB01 = 13'h0004;
  localparam logic [12:0] O_HALT = 13'h0002;
  localparam logic [12:0] O_MERR = 13'h0001;
  localparam logic [12:0] O_FETCH_HIT = O_IMEM | O_IRL | O_PCI;

  logic             clk = 1'b0;
  logic             rst, branch_cond, imem_ready, dmem_ready, resume;
  logic [5:0]       opcode;
  logic             imem_req, ir_load, pc_inc, pc_branch, reg_read, alu_en;
  logic             dmem_req, dmem_we, reg_we, halted, mem_err;
  logic [1:0]       wb_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic [12:0]      outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign outs = {imem_req, ir_load, pc_inc, pc_branch, reg_read, alu_en,
                 dmem_req, dmem_we, reg_we, wb_sel, halted, mem_err};

  multicycle_sequencer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .branch_cond (branch_cond),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .resume      (resume),
    .imem_req    (imem_req),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .reg_read    (reg_read),
    .alu_en      (alu_en),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .mem_err     (mem_err),
    .state       (state),
    .instr_count (instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and outputs mid-cycle, then advance to just past the next edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] v);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_outs"}, 32'(outs), 32'(v));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; opcode = 6'd0; branch_cond = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_cnt", 32'(instr_count), 32'd0);
    rst = 1'b1;

    // ALU, ready tied high: 0,1,2,4 then back to FETCH.
    opcode = 6'b000010;
    cyc("alu_f", 3'd0, O_FETCH_HIT);
    cyc("alu_d", 3'd1, O_RR);
    cyc("alu_e", 3'd2, O_ALU);
    cyc("alu_w", 3'd4, O_RWE);
    check("alu_cnt", 32'(instr_count), 32'd1);

    // LOAD, dmem_ready arrives on the 4th MEM cycle (timeout boundary: ready wins).
    opcode = 6'b010000; dmem_ready = 1'b0;
    cyc("ld_f", 3'd0, O_FETCH_HIT);
    cyc("ld_d", 3'd1, O_RR);
    cyc("ld_e", 3'd2, O_ALU);
    for (int i = 0; i < 3; i++) cyc("ld_mwait", 3'd3, O_DREQ);
    dmem_ready = 1'b1;
    cyc("ld_mrdy", 3'd3, O_DREQ);
    cyc("ld_w", 3'd4, O_RWE | O_WB01);
    check("ld_cnt", 32'(instr_count), 32'd2);
    check("ld_noerr", 32'(mem_err), 32'd0);

    // STORE: write during MEM, no WB.
    opcode = 6'b011000;
    cyc("st_f", 3'd0, O_FETCH_HIT);
    cyc("st_d", 3'd1, O_RR);
    cyc("st_e", 3'd2, O_ALU);
    cyc("st_m", 3'd3, O_DREQ | O_DWE);
    check("st_cnt", 32'(instr_count), 32'd3);

    // Plain BRANCH taken: 3 cycles; 4th retirement wraps the 2-bit counter.
    opcode = 6'b110000; branch_cond = 1'b1;
    cyc("br_f", 3'd0, O_FETCH_HIT);
    cyc("br_d", 3'd1, O_RR);
    cyc("br_e", 3'd2, O_ALU | O_PCB);
    check("br_back", 32'(state), 32'd0);
    check("br_wrap", 32'(instr_count), 32'd0);

    // BRANCH_LINK not taken: writeback of PC.
    opcode = 6'b110011; branch_cond = 1'b0;
    cyc("bl_f", 3'd0, O_FETCH_HIT);
    cyc("bl_d", 3'd1, O_RR);
    cyc("bl_e", 3'd2, O_ALU);
    cyc("bl_w", 3'd4, O_RWE | O_WB10);
    check("bl_cnt", 32'(instr_count), 32'd1);

    // LOAD with dmem_ready never asserted: 4 MEM cycles then HALT with error.
    opcode = 6'b010000; dmem_ready = 1'b0;
    cyc("to_f", 3'd0, O_FETCH_HIT);
    cyc("to_d", 3'd1, O_RR);
    cyc("to_e", 3'd2, O_ALU);
    for (int i = 0; i < 4; i++) cyc("to_m", 3'd3, O_DREQ);
    cyc("to_halt", 3'd5, O_HALT | O_MERR);
    check("to_cnt", 32'(instr_count), 32'd1);
    resume = 1'b1;
    cyc("to_resume", 3'd5, O_HALT | O_MERR);
    resume = 1'b0; imem_ready = 1'b0;

    // Fetch timeout after resume; mem_err stays sticky.
    for (int i = 0; i < 4; i++) cyc("fto_f", 3'd0, O_IMEM | O_MERR);
    cyc("fto_halt", 3'd5, O_HALT | O_MERR);

    // resume together with reset: reset wins and clears mem_err.
    resume = 1'b1; rst = 1'b0;
    #1;
    check("rr_outs_in_rst", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; resume = 1'b0;
    #1;
    check("rr_state", 32'(state), 32'd0);
    check("rr_outs", 32'(outs), 32'(O_IMEM));
    check("rr_cnt", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;

    // HALT opcode: halted after 2 cycles, retired.
    imem_ready = 1'b1; opcode = 6'b111111;
    cyc("hlt_f", 3'd0, O_FETCH_HIT);
    cyc("hlt_d", 3'd1, O_RR);
    check("hlt_cnt", 32'(instr_count), 32'd1);
    resume = 1'b1;
    cyc("hlt_h", 3'd5, O_HALT);
    resume = 1'b0;

    // Reset asserted mid-MEM abandons the load.
    opcode = 6'b010000; dmem_ready = 1'b0;
    cyc("mr_f", 3'd0, O_FETCH_HIT);
    cyc("mr_d", 3'd1, O_RR);
    cyc("mr_e", 3'd2, O_ALU);
    cyc("mr_m", 3'd3, O_DREQ);
    rst = 1'b0;
    #1;
    check("mr_outs_in_rst", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    check("mr_state_in_rst", 32'(state), 32'd0);
    check("mr_outs_after_edge", 32'(outs), 32'd0);
    rst = 1'b1;
    #1;
    check("mr_state", 32'(state), 32'd0);
    check("mr_cnt", 32'(instr_count), 32'd0);
    check("mr_outs", 32'(outs), 32'(O_FETCH_HIT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the KGP miniRISC datapath through FETCH / DECODE / EXEC / MEM / WB, one instruction at a time.
- Handles the instruction-memory and data-memory request/ready handshakes.
- Drives per-cycle enables: IR load, PC update, ALU, register write, memory request.
- Sits between the opcode field of the IR and the datapath enables; provides halt, resume, memory timeout and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request waits for ready before error; legal range 2..255.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- branch_cond  in  1  datapath flag; 1 = branch taken, sampled in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- resume  in  1  leave HALT
- imem_req  out  1  instruction fetch request
- ir_load  out  1  latch instruction register
- pc_inc  out  1  PC <= PC+4
- pc_branch  out  1  PC <= branch target
- reg_read  out  1  register file read enable
- alu_en  out  1  ALU operand/result latch enable
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (valid only with dmem_req)
- reg_we  out  1  register file write enable
- wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 PC (link)
- halted  out  1  FSM in HALT
- mem_err  out  1  sticky timeout flag
- state  out  3  current state encoding
- instr_count  out  CNT_W  retired instructions, wraps to 0

Behaviour:
- Opcode classes:
  - LOAD = 010000
  - STORE = 011000
  - HALT = 111111
  - BRANCH = 11xxxx excluding HALT; a branch with opcode[1:0]=11 is BRANCH_LINK
  - ALU = every other opcode (R-type 00xxxx, immediate 01xxxx/10xxxx)
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 go to FETCH next cycle.
- Registers: state, wait counter (8 bit), mem_err, instr_count. All outputs decode combinationally from the registered state plus the current inputs.
- Reset (rst=0 at a clock edge):
  - state=FETCH, counter=0, mem_err=0, instr_count=0.
  - While rst=0, force every output to 0, including imem_req.
  - Reset mid-operation abandons the instruction; any outstanding memory request is simply dropped.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_load=1 and pc_inc=1 in the same cycle, then go to DECODE.
  - Otherwise increment the counter; if it reaches MEM_TIMEOUT-1 without ready, set mem_err=1 and go to HALT.
- DECODE: reg_read=1 for 1 cycle. HALT opcode goes to HALT (retired, instr_count+1); all other opcodes go to EXEC.
- EXEC: alu_en=1 for 1 cycle.
  - ALU goes to WB.
  - LOAD/STORE go to MEM.
  - BRANCH: pc_branch = branch_cond. BRANCH_LINK goes to WB; plain BRANCH retires and goes to FETCH.
- MEM:
  - dmem_req=1 and dmem_we=(STORE), both held stable until dmem_ready.
  - On dmem_ready: LOAD goes to WB; STORE retires and goes to FETCH.
  - Timeout works the same as in FETCH.
- WB:
  - reg_we=1 for 1 cycle.
  - wb_sel: 01 for LOAD, 10 for BRANCH_LINK, 00 otherwise. wb_sel is 00 outside WB.
  - Retires, then goes to FETCH.
- The wait counter clears on every state change.
- HALT:
  - halted=1; all other enables are 0.
  - resume=1 goes to FETCH. mem_err is not cleared by resume; only rst clears it.
- Retire rule: instr_count increments by exactly 1 in the final cycle of each instruction and wraps modulo 2^CNT_W. Timeout aborts do not retire.
- Latency with ready asserted immediately:
  - ALU: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - plain BRANCH: 3 cycles
  - BRANCH_LINK: 4 cycles
  - HALT: 2 cycles
- Simultaneous events:
  - Ready on the same cycle the counter hits MEM_TIMEOUT-1: ready wins, no error.
  - resume with rst=0: reset wins.

Decomposition:
- Shared package miniRISC_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_HALT
  - state localparams S_FETCH..S_HALT
  - wb_sel codes WB_ALU, WB_MEM, WB_PC
- One natural sub-module: opcode_classifier (combinational), producing is_load, is_store, is_branch, is_link, is_halt, is_alu; reusable by later hazard logic.

Test Plan:
- ALU opcode 000010, imem_ready and dmem_ready tied 1 -> states 0,1,2,4,0; reg_we high only in WB with wb_sel=00; instr_count 0 -> 1 after 4 cycles.
- LOAD 010000, dmem_ready delayed 3 cycles -> dmem_req=1 and dmem_we=0 held for 4 cycles; WB with wb_sel=01; total 8 cycles; mem_err=0.
- STORE 011000 -> dmem_we=1 during MEM, no WB, reg_we never asserted; BRANCH 110000 with branch_cond=1 -> pc_branch=1 in EXEC, back to FETCH after 3 cycles.
- BRANCH_LINK 110011, branch_cond=0 -> pc_branch=0, WB with wb_sel=10, reg_we=1.
- MEM_TIMEOUT=4, dmem_ready never asserted on a LOAD -> after 4 MEM cycles mem_err=1, halted=1, instr_count unchanged; resume -> FETCH with mem_err still 1; rst=0 -> mem_err=0.
- HALT 111111 -> halted in 2 cycles with instr_count+1. Separately, rst=0 asserted mid-MEM -> next cycle state=0 with all outputs 0. CNT_W=2 with 4 retirements -> instr_count wraps to 0.
